bpsk_chip_scheduler: RTL

Sequences one BPSK burst for the sine DDS. Each frame is a fixed preamble, then payload bits pulled from an upstream source through a valid/ready handshake, then a silent guard gap. Every bit is spread by a 31-chip Gold code. The block drives the DDS 11-bit phase word, whose MSB selects 0°/180°, so every chip transition becomes a phase flip.

---
 rtl/bpsk_pkg.sv | 19 +
 rtl/bpsk_chip_scheduler_gold.sv | 40 ++++
 rtl/bpsk_chip_scheduler.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/bpsk_pkg.sv
// Shared types and constants for the BPSK chip scheduler and its Gold-code generator.
package bpsk_pkg;
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_GAP      = 2'd3
  } bpsk_state_t;

  localparam int         GOLD_LEN    = 31;
  localparam logic [4:0] LFSR_A_SEED = 5'b00001;
  localparam logic [4:0] TAPS_A      = 5'b00101;
  localparam logic [4:0] TAPS_B      = 5'b11101;

  // Fibonacci LFSR, shifting right, feedback into the MSB.
  function automatic logic [4:0] lfsr_next(input logic [4:0] s, input logic [4:0] taps);
    return {^(s & taps), s[4:1]};
  endfunction
endpackage

// File: rtl/bpsk_chip_scheduler_gold.sv
// Gold-code generator: two 5-bit LFSRs XORed together, one step per chip.
module gold_gen
  import bpsk_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  input  logic [4:0] seed_b,
  output logic       code
);
  logic [4:0] a_q, a_d;
  logic [4:0] b_q, b_d;

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (load) begin
      a_d = LFSR_A_SEED;
      b_d = seed_b;
    end else if (step) begin
      a_d = lfsr_next(a_q, TAPS_A);
      b_d = lfsr_next(b_q, TAPS_B);
    end
  end

  // Lookahead: code belongs to the state being entered, so a registered
  // consumer shows it in the same cycle the LFSRs hold it.
  assign code = a_d[0] ^ b_d[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= LFSR_A_SEED;
      b_q <= 5'b00001;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end
endmodule

// File: rtl/bpsk_chip_scheduler.sv
// BPSK burst sequencer: preamble, handshaked payload, guard gap; Gold-spread chips to the DDS.
// Define BPSK_DIFF_EN to differentially encode the transmitted bits.
module bpsk_chip_scheduler
  import bpsk_pkg::*;
#(
  parameter int CHIP_DIV      = 32,
  parameter int PREAMBLE_BITS = 8,
  parameter int PAYLOAD_BITS  = 64,
  parameter int GAP_CYCLES    = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  gold_sel,
  input  logic        data_bit,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [10:0] pword,
  output logic        chip_strobe,
  output logic        busy,
  output logic        done,
  output logic        err_underflow
);
  localparam int BIT_MAX = (PREAMBLE_BITS > PAYLOAD_BITS) ? PREAMBLE_BITS : PAYLOAD_BITS;
  localparam int DIV_W   = $clog2(CHIP_DIV);
  localparam int BIT_W   = $clog2(BIT_MAX + 1);
  localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CHIP_DIV - 1);
  localparam logic [4:0]       CHIP_LAST = 5'(GOLD_LEN - 1);
  localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(PREAMBLE_BITS - 1);
  localparam logic [BIT_W-1:0] PAY_LAST  = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  bpsk_state_t      state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [4:0]       chip_idx_q, chip_idx_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [4:0]       seed_q, seed_d;
  logic             cur_bit_q, cur_bit_d;
  logic [10:0]      pword_q, pword_d;
  logic             strobe_q, strobe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic       load, step, code, chip_on, at_div_last, boundary, prev_bit;
  logic [4:0] seed_b, fixed_sel;

`ifdef BPSK_DIFF_EN
  assign prev_bit = cur_bit_q;
`else
  assign prev_bit = 1'b0;
`endif

  assign fixed_sel   = (gold_sel == 5'd0) ? 5'b00001 : gold_sel;
  assign at_div_last = (div_cnt_q == DIV_LAST);
  assign boundary    = at_div_last && (chip_idx_q == CHIP_LAST);

  gold_gen u_gold (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .seed_b (seed_b),
    .code   (code)
  );

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    chip_idx_d = chip_idx_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    seed_d     = seed_q;
    cur_bit_d  = cur_bit_q;
    strobe_d   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    data_ready = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    chip_on    = 1'b0;
    seed_b     = seed_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_PREAMBLE;
          seed_d     = fixed_sel;
          seed_b     = fixed_sel;
          load       = 1'b1;
          div_cnt_d  = '0;
          chip_idx_d = '0;
          bit_cnt_d  = '0;
          cur_bit_d  = 1'b0;
          strobe_d   = 1'b1;
          chip_on    = 1'b1;
        end
      end
      ST_PREAMBLE, ST_PAYLOAD: begin
        chip_on   = 1'b1;
        div_cnt_d = at_div_last ? '0 : div_cnt_q + 1'b1;
        if (at_div_last && !boundary) begin
          chip_idx_d = chip_idx_q + 1'b1;
          step       = 1'b1;
          strobe_d   = 1'b1;
        end else if (boundary) begin
          chip_idx_d = '0;
          if (state_q == ST_PAYLOAD && bit_cnt_q == PAY_LAST) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
            bit_cnt_d = '0;
            chip_on   = 1'b0;
          end else if (state_q == ST_PREAMBLE && bit_cnt_q != PRE_LAST) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            load      = 1'b1;
            strobe_d  = 1'b1;
            cur_bit_d = prev_bit;
          end else begin
            // Next bit comes from upstream: this is the only place a transfer can happen.
            data_ready = 1'b1;
            if (data_valid) begin
              state_d   = ST_PAYLOAD;
              bit_cnt_d = (state_q == ST_PREAMBLE) ? '0 : bit_cnt_q + 1'b1;
              load      = 1'b1;
              strobe_d  = 1'b1;
              cur_bit_d = data_bit ^ prev_bit;
            end else begin
              state_d   = ST_IDLE;
              bit_cnt_d = '0;
              err_d     = 1'b1;
              chip_on   = 1'b0;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
          done_d    = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pword_d = chip_on ? {code ^ cur_bit_d, 10'd0} : 11'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      chip_idx_q <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      seed_q     <= 5'b00001;
      cur_bit_q  <= 1'b0;
      pword_q    <= 11'd0;
      strobe_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      chip_idx_q <= chip_idx_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      seed_q     <= seed_d;
      cur_bit_q  <= cur_bit_d;
      pword_q    <= pword_d;
      strobe_q   <= strobe_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign pword         = pword_q;
  assign chip_strobe   = strobe_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign err_underflow = err_q;
endmodule
